otter_instr_encoder: RTL

OTTER_INSTR_ENCODER -- requirements
Module: otter_instr_encoder

---
 rtl/otter_enc_pkg.sv | 38 +++
 rtl/enc_imm_fmt.sv | 51 +++++
 rtl/otter_instr_encoder.sv | 128 ++++++++++++
 3 files changed

// File: rtl/otter_enc_pkg.sv
// Shared types and RV32I encoding constants for the OTTER instruction encoder.
package otter_enc_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_XOR  = 4'd1,
        OP_SLT  = 4'd2,
        OP_ADDI = 4'd3,
        OP_SLLI = 4'd4,
        OP_BEQ  = 4'd5,
        OP_LUI  = 4'd6,
        OP_JAL  = 4'd7
    } enc_op_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } enc_state_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_ADDI = 3'b000;
    localparam logic [2:0] F3_SLLI = 3'b001;
    localparam logic [2:0] F3_BEQ  = 3'b000;

    localparam logic [6:0] F7_ZERO = 7'b0000000;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

endpackage

// File: rtl/enc_imm_fmt.sv
// Places a request immediate into its RV32I bit positions and flags out-of-range values.
// Range checking is compiled in only when ENCODER_RANGE_CHECK_EN is defined.
module enc_imm_fmt
    import otter_enc_pkg::*;
(
    input  logic [3:0]  req_op,
    input  logic [31:0] req_imm,
    output logic [31:0] imm_bits,
    output logic        imm_err
);

    enc_op_t op;

    assign op = enc_op_t'(req_op);

    always_comb begin
        imm_bits = '0;
        case (op)
            OP_ADDI: imm_bits = {req_imm[11:0], 20'b0};
            OP_SLLI: imm_bits = {F7_ZERO, req_imm[4:0], 20'b0};
            OP_BEQ:  imm_bits = {req_imm[12], req_imm[10:5], 13'b0,
                                 req_imm[4:1], req_imm[11], 7'b0};
            OP_LUI:  imm_bits = {req_imm[31:12], 12'b0};
            OP_JAL:  imm_bits = {req_imm[20], req_imm[10:1], req_imm[11],
                                 req_imm[19:12], 12'b0};
            default: imm_bits = '0;
        endcase
    end

`ifdef ENCODER_RANGE_CHECK_EN
    logic signed [31:0] simm;

    assign simm = $signed(req_imm);

    always_comb begin
        imm_err = 1'b0;
        case (op)
            OP_ADDI: imm_err = (simm < -2048) || (simm > 2047);
            // unsigned compare also rejects negative shift amounts
            OP_SLLI: imm_err = (req_imm > 32'd31);
            OP_BEQ:  imm_err = req_imm[0] || (simm < -4096) || (simm > 4094);
            OP_JAL:  imm_err = req_imm[0] || (simm < -1048576) || (simm > 1048574);
            OP_LUI:  imm_err = (req_imm[11:0] != 12'd0);
            default: imm_err = 1'b0;
        endcase
    end
`else
    assign imm_err = 1'b0;
`endif

endmodule

// File: rtl/otter_instr_encoder.sv
// Encodes RV32I instruction requests and streams the words into instruction memory.
// Optional immediate range checking: define ENCODER_RANGE_CHECK_EN.
module otter_instr_encoder
    import otter_enc_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_rs1,
    input  logic [4:0]  req_rs2,
    input  logic [31:0] req_imm,
    input  logic        req_last,
    output logic        mem_we,
    output logic [13:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    output logic        done,
    output logic        err_imm,
    output logic [14:0] count
);

    enc_state_t state, state_nxt;
    enc_op_t    op;
    logic [31:0] imm_bits;
    logic        imm_err;
    logic [31:0] enc_word;
    logic        enc_err;
    logic        last_q;
    logic        accept;
    logic        write_done;

    enc_imm_fmt u_imm_fmt (
        .req_op   (req_op),
        .req_imm  (req_imm),
        .imm_bits (imm_bits),
        .imm_err  (imm_err)
    );

    assign op = enc_op_t'(req_op);

    // Unused register fields are forced to zero per instruction format.
    always_comb begin
        enc_word = NOP_WORD;
        enc_err  = imm_err;
        case (op)
            OP_ADD:  enc_word = {F7_ZERO, req_rs2, req_rs1, F3_ADD, req_rd, OPC_OP};
            OP_XOR:  enc_word = {F7_ZERO, req_rs2, req_rs1, F3_XOR, req_rd, OPC_OP};
            OP_SLT:  enc_word = {F7_ZERO, req_rs2, req_rs1, F3_SLT, req_rd, OPC_OP};
            OP_ADDI: enc_word = imm_bits | {12'b0, req_rs1, F3_ADDI, req_rd, OPC_OP_IMM};
            OP_SLLI: enc_word = imm_bits | {12'b0, req_rs1, F3_SLLI, req_rd, OPC_OP_IMM};
            OP_BEQ:  enc_word = imm_bits | {7'b0, req_rs2, req_rs1, F3_BEQ, 5'b0, OPC_BRANCH};
            OP_LUI:  enc_word = imm_bits | {20'b0, req_rd, OPC_LUI};
            OP_JAL:  enc_word = imm_bits | {20'b0, req_rd, OPC_JAL};
            default: begin
                enc_word = NOP_WORD;
                enc_err  = 1'b1;
            end
        endcase
    end

    assign accept     = (state == S_IDLE) && req_valid && !start;
    assign write_done = (state == S_WRITE) && mem_ready && !start;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (req_valid) state_nxt = S_WRITE;
                S_WRITE: if (mem_ready) state_nxt = last_q ? S_DONE : S_IDLE;
                S_DONE:  state_nxt = S_DONE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        req_ready = 1'b0;
        mem_we    = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE:  req_ready = !start;
            S_WRITE: mem_we    = 1'b1;
            S_DONE:  done      = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            count     <= '0;
            err_imm   <= 1'b0;
            last_q    <= 1'b0;
        end else if (start) begin
            mem_addr <= '0;
            count    <= '0;
            err_imm  <= 1'b0;
        end else begin
            if (accept) begin
                mem_wdata <= enc_word;
                last_q    <= req_last;
                err_imm   <= err_imm | enc_err;
            end
            if (write_done) begin
                mem_addr <= mem_addr + 14'd1;
                if (count != '1) begin
                    count <= count + 15'd1;
                end
            end
        end
    end

endmodule
